// File: rtl/uart_rx_mailbox_pkg.sv
// Shared types and constants for the UART receive mailbox.
// Optional even-parity support is enabled by defining UART_RX_PARITY_EN.
package uart_rx_pkg;

  localparam int UART_DATA_BITS            = 8;
  localparam int UART_DEFAULT_CLKS_PER_BIT = 868;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_rx_mailbox_if.sv
// Core-facing read/status bundle of the UART receive mailbox.
// The mailbox drives the slave side, the MIPS core the master side.
interface uart_rx_mailbox_if #(
  parameter int DEPTH = 8
);
  import uart_rx_pkg::*;

  // rd_data is valid whenever rx_avail=1; a cycle with rd_en=1 and
  // rx_avail=1 consumes the head, and rd_en while empty is ignored.
  logic                       rd_en;
  logic                       clr_err;
  logic [7:0]                 rd_data;
  logic                       rx_avail;
  logic                       rx_full;
  logic [$clog2(DEPTH+1)-1:0] byte_count;
  logic                       overrun;
  logic                       frame_err;
  logic                       parity_err;
  rx_state_e                  state_dbg;

  modport master (
    output rd_en, clr_err,
    input  rd_data, rx_avail, rx_full, byte_count,
    input  overrun, frame_err, parity_err, state_dbg
  );

  modport slave (
    input  rd_en, clr_err,
    output rd_data, rx_avail, rx_full, byte_count,
    output overrun, frame_err, parity_err, state_dbg
  );

endinterface

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte FIFO; pointers carry one extra wrap bit
// so full and empty are distinguishable without a separate counter.
module uart_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign count_o = wptr_q - rptr_q;
  assign head_o  = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];

  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/uart_rx_mailbox.sv
// UART receiver with sticky error flags feeding a byte FIFO for the MIPS core.
// Define UART_RX_PARITY_EN to receive an even-parity bit between data and stop.
module uart_rx_mailbox
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
  parameter int DEPTH        = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rx,
  uart_rx_mailbox_if.slave  mb
);
  localparam int              CW            = $clog2(CLKS_PER_BIT);
  localparam int              NW            = $clog2(DEPTH+1);
  localparam logic [CW-1:0]   HALF_LAST     = CW'(CLKS_PER_BIT/2 - 1);
  localparam logic [CW-1:0]   BIT_LAST      = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]      LAST_DATA_BIT = 3'(UART_DATA_BITS - 1);

  logic                      rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_e                 state_q, state_d;
  logic [CW-1:0]             cyc_q, cyc_d;
  logic [2:0]                bit_q, bit_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      overrun_q, overrun_d;
  logic                      frame_err_q, frame_err_d;
  logic                      set_over, set_frame, push;
  logic                      fifo_full, fifo_empty;
  logic [7:0]                fifo_head;
  logic [NW-1:0]             fifo_count;
`ifdef UART_RX_PARITY_EN
  logic                      par_bad_q, par_bad_d;
  logic                      parity_err_q, parity_err_d;
  logic                      set_par;
`endif

  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q + 1'b1;
    bit_d     = bit_q;
    shift_d   = shift_q;
    set_over  = 1'b0;
    set_frame = 1'b0;
    push      = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    set_par   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        cyc_d = '0;
        // Edge-triggered start: a line held low after a break never restarts.
        if (!rx_sync_q && rx_prev_q) state_d = ST_START;
      end
      ST_START: begin
        if (cyc_q == HALF_LAST) begin
          cyc_d = '0;
          bit_d = '0;
          state_d = rx_sync_q ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (cyc_q == BIT_LAST) begin
          cyc_d   = '0;
          shift_d = {rx_sync_q, shift_q[UART_DATA_BITS-1:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == LAST_DATA_BIT) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (cyc_q == BIT_LAST) begin
          cyc_d     = '0;
          par_bad_d = ^{shift_q, rx_sync_q};
          state_d   = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (cyc_q == BIT_LAST) begin
          cyc_d   = '0;
          state_d = ST_IDLE;
          if (!rx_sync_q) begin
            set_frame = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if (par_bad_q) begin
            set_par = 1'b1;
`endif
          end else if (fifo_full && !mb.rd_en) begin
            set_over = 1'b1;
          end else begin
            push = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    overrun_d   = set_over  | (overrun_q   & ~mb.clr_err);
    frame_err_d = set_frame | (frame_err_q & ~mb.clr_err);
`ifdef UART_RX_PARITY_EN
    parity_err_d = set_par  | (parity_err_q & ~mb.clr_err);
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_prev_q   <= 1'b1;
      state_q     <= ST_IDLE;
      cyc_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_meta_q   <= rx;
      rx_sync_q   <= rx_meta_q;
      rx_prev_q   <= rx_sync_q;
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
    end
  end
  assign mb.parity_err = parity_err_q;
`else
  assign mb.parity_err = 1'b0;
`endif

  uart_rx_fifo #(.DEPTH(DEPTH), .WIDTH(UART_DATA_BITS)) u_fifo (
    .clk     (clock),
    .rst     (reset),
    .push_i  (push),
    .data_i  (shift_q),
    .pop_i   (mb.rd_en),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign mb.rd_data    = fifo_head;
  assign mb.rx_avail   = !fifo_empty;
  assign mb.rx_full    = fifo_full;
  assign mb.byte_count = fifo_count;
  assign mb.overrun    = overrun_q;
  assign mb.frame_err  = frame_err_q;
  assign mb.state_dbg  = state_q;

endmodule

// File: doc/uart_rx_mailbox.md
# uart_rx_mailbox

Receive-side counterpart of the MIPS UART transmit path. The block deserializes the `rx` line into bytes, checks framing and, optionally, parity, and buffers good bytes in a small FIFO. The MIPS core pops bytes through a first-word-fall-through read port. It runs in the 100 MHz PLL domain alongside the MIPS core and the UART transmitter.

## Interface
- `CLKS_PER_BIT`, 868, clock cycles per bit (100 MHz / 115200); minimum 8.
- `DEPTH`, 8, FIFO entries; power of two, minimum 2.
- `clock`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `rx`  in  1  serial line, idle high, asynchronous to `clock`.
- `rd_en`  in  1  pops the FIFO head this cycle; ignored when empty.
- `clr_err`  in  1  clears all sticky error flags.
- `rd_data`  out  8  FIFO head byte; 0 when empty.
- `rx_avail`  out  1  FIFO non-empty.
- `rx_full`  out  1  FIFO holds `DEPTH` bytes.
- `byte_count`  out  $clog2(DEPTH+1)  current occupancy.
- `overrun`  out  1  sticky; a good byte was dropped because the FIFO was full.
- `frame_err`  out  1  sticky; the stop bit was sampled low.
- `parity_err`  out  1  sticky; parity mismatch. Tied 0 when parity is compiled out.

## Operation
- `rx` passes through a 2-flop synchronizer; both flops reset to 1. All sampling uses the synchronized value.
- A bit counter (0..7) and a cycle counter (0..`CLKS_PER_BIT`-1) drive the state machine.
- FSM states: IDLE, START, DATA, PARITY (present only with the macro), STOP.
- IDLE: a synchronized 1→0 transition moves to START and clears the cycle counter.
- START: sample at count `CLKS_PER_BIT/2`-1.
  - Sampled high: false start; return to IDLE with no flags set.
  - Sampled low: move to DATA; the cycle counter restarts, so later samples land mid-bit.
- DATA: sample every `CLKS_PER_BIT` cycles into a shift register, LSB first. After bit 7, go to PARITY if compiled in, otherwise STOP.
- PARITY: sample one bit. Even parity is required: the XOR of the 8 data bits and the parity bit must be 0. The result is held until STOP.
- STOP: sample one bit, then return to IDLE immediately, at mid-stop-bit.
  - Stop bit = 0: set `frame_err` and discard the byte. The parity result is not flagged.
  - Stop bit = 1 with parity bad: set `parity_err` and discard the byte.
  - Stop bit = 1 with parity good and FIFO not full: push the byte.
  - Stop bit = 1 with parity good and FIFO full: set `overrun` and discard the byte.
- After a frame error with `rx` held low (break condition), no new frame starts until the line goes high and then falls again.
- Push while full coinciding with `rd_en` is treated as not full: the pop and push both happen, and `overrun` stays clear.
- `clr_err` asserted in the same cycle a flag sets: the set wins.
- Reset mid-frame: the partial byte is discarded, the FIFO is emptied, and the FSM returns to IDLE.

## Timing
- Reset values: `rd_data`=0, `rx_avail`=0, `rx_full`=0, `byte_count`=0, all error flags 0, FSM in IDLE.
- Latency from the falling edge of `rx` to `rx_avail` rising:
  - without parity: 2 + `CLKS_PER_BIT/2` + 9·`CLKS_PER_BIT` + 1 cycles;
  - with parity: add `CLKS_PER_BIT`.
- `rd_data` is valid whenever `rx_avail`=1 (first-word fall-through).
  - A pop on cycle N presents the next byte on cycle N+1.
  - `byte_count` updates on N+1.
- Error flags assert on the cycle after the STOP sample.
- One byte per frame. Back-to-back frames with zero idle time are received without loss.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - the frame is start + 8 data + even parity + stop;
  - the PARITY state and `parity_err` logic are built.
- `UART_RX_PARITY_EN` undefined:
  - the frame is start + 8 data + stop;
  - the PARITY state is absent and `parity_err` is constant 0.

## Structure
- Package `uart_rx_pkg` holds:
  - the FSM state enum;
  - `UART_DATA_BITS`=8;
  - `UART_DEFAULT_CLKS_PER_BIT`=868.
- Sub-module `uart_rx_fifo` (parameter `DEPTH`, width 8) provides:
  - push, pop, head, full, empty and count;
  - wrap-around read/write pointers one bit wider than the address, to distinguish full from empty.
- The top of `uart_rx_mailbox` contains the synchronizer, the counters, the FSM and the error flags.

## Test plan
All scenarios use `CLKS_PER_BIT`=16 and `DEPTH`=4.
- Send 0xA5 as a valid frame → after the computed latency, `rx_avail`=1, `rd_data`=0xA5, `byte_count`=1. One `rd_en` pulse → `rx_avail`=0, `rd_data`=0.
- Send 5 back-to-back frames 0x01..0x05 with no reads:
  - after the 4th frame: `rx_full`=1;
  - after the 5th frame: `overrun`=1;
  - reads return 0x01, 0x02, 0x03, 0x04.
- Send a frame 0x3C with the stop bit forced low → `frame_err`=1, FIFO unchanged. `clr_err` → flag returns to 0.
- Pulse `rx` low for 4 cycles → glitch rejected: no push and no flags.
- With `UART_RX_PARITY_EN`:
  - send 0x07 with parity bit 1 → pushed;
  - send 0x07 with parity bit 0 → `parity_err`=1, no push.
- Assert `reset` mid-DATA after 3 bits → all outputs return to reset values; the next full frame 0x5A is received correctly.
